// File: rtl/serial_feeder_pkg.sv
// Shared types and widths for the serial feeder: FSM state encoding and
// the word/bit-index widths that match the downstream 8-bit shift register.
package serial_feeder_pkg;

  localparam int WORD_W    = 8;
  localparam int BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    SYNC,
    SHIFT,
    INVERT
  } state_e;

endpackage

// File: rtl/feeder_fifo.sv
// Single-clock FIFO buffering parallel bytes ahead of the serialiser.
// Push while full is accepted only if a pop frees an entry in the same cycle.
module feeder_fifo
  import serial_feeder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [WORD_W-1:0]         wdata,
  input  logic                      pop,
  output logic [WORD_W-1:0]         rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               do_push, do_pop;

  assign full    = (level_q == LEVEL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: a flushed FIFO never exposes stale entries.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/serial_feeder.sv
// Serialises buffered bytes LSB first onto a reset-less shift register and
// drives its functional line (1 = shift, 0 = invert + realign).
// Optional tx_count output enabled by defining SERIAL_FEEDER_BYTE_CNT_EN.
module serial_feeder
  import serial_feeder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WORD_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   inv_req,
  output logic                   ser_bit,
  output logic                   functional,
  output logic                   word_done,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef SERIAL_FEEDER_BYTE_CNT_EN
  ,
  output logic [15:0]            tx_count
`endif
);

  localparam int                 LEVEL_W  = $clog2(DEPTH) + 1;
  localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]     cur_q, cur_d;
  logic [WIDTH-1:0]     shadow_q, shadow_d;
  logic                 inv_pend_q, inv_pend_d;
  logic                 ser_bit_q, ser_bit_d;
  logic                 functional_q, functional_d;
  logic                 word_done_q, word_done_d;
  logic                 in_ready_q, in_ready_d;

  logic                 push, pop;
  logic [WIDTH-1:0]     fifo_rdata;
  logic                 fifo_full, fifo_empty;
  logic [LEVEL_W-1:0]   level_nxt;

  assign push = in_valid && in_ready_q && !fifo_full;

  feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (in_data),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    cur_d      = cur_q;
    shadow_d   = shadow_q;
    inv_pend_d = inv_pend_q | inv_req;
    pop        = 1'b0;

    case (state_q)
      SYNC: begin
        state_d   = SHIFT;
        bit_idx_d = '0;
        cur_d     = shadow_q;
      end
      SHIFT: begin
        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
        if (bit_idx_q == LAST_IDX) begin
          shadow_d = cur_q;
          if (inv_pend_q || inv_req) begin
            state_d = INVERT;
          end else if (!fifo_empty) begin
            pop   = 1'b1;
            cur_d = fifo_rdata;
          end
        end
      end
      INVERT: begin
        state_d    = SHIFT;
        bit_idx_d  = '0;
        shadow_d   = ~shadow_q;
        inv_pend_d = 1'b0;
        if (!fifo_empty) begin
          pop   = 1'b1;
          cur_d = fifo_rdata;
        end else begin
          cur_d = ~shadow_q;
        end
      end
      default: state_d = SYNC;
    endcase

    level_nxt    = fifo_level + LEVEL_W'(push) - LEVEL_W'(pop);
    in_ready_d   = (level_nxt < LEVEL_W'(DEPTH));
    functional_d = (state_d == SHIFT);
    ser_bit_d    = (state_d == SHIFT) ? cur_d[bit_idx_d] : 1'b0;
    word_done_d  = (state_d == SHIFT) && (bit_idx_d == LAST_IDX);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SYNC;
      bit_idx_q    <= '0;
      cur_q        <= '0;
      shadow_q     <= '0;
      inv_pend_q   <= 1'b0;
      ser_bit_q    <= 1'b0;
      functional_q <= 1'b0;
      word_done_q  <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_idx_q    <= bit_idx_d;
      cur_q        <= cur_d;
      shadow_q     <= shadow_d;
      inv_pend_q   <= inv_pend_d;
      ser_bit_q    <= ser_bit_d;
      functional_q <= functional_d;
      word_done_q  <= word_done_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign ser_bit    = ser_bit_q;
  assign functional = functional_q;
  assign word_done  = word_done_q;
  assign in_ready   = in_ready_q;

`ifdef SERIAL_FEEDER_BYTE_CNT_EN
  logic        from_fifo_q, from_fifo_d;
  logic [15:0] tx_count_q, tx_count_d;

  // Only words that were popped count; refills and post-invert refills do not.
  always_comb begin
    from_fifo_d = from_fifo_q;
    if ((state_d == SHIFT) && (bit_idx_d == '0)) from_fifo_d = pop;
    tx_count_d = tx_count_q;
    if ((state_q == SHIFT) && (bit_idx_q == LAST_IDX) && from_fifo_q)
      tx_count_d = tx_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      from_fifo_q <= 1'b0;
      tx_count_q  <= '0;
    end else begin
      from_fifo_q <= from_fifo_d;
      tx_count_q  <= tx_count_d;
    end
  end

  assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_serial_feeder.sv
// Directed bench for serial_feeder with a behavioural model of the
// downstream reset-less shift register driven by ser_bit/functional.
module tb_serial_feeder;

  logic       clock;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       inv_req;
  logic       ser_bit;
  logic       functional;
  logic       word_done;
  logic [2:0] fifo_level;
`ifdef SERIAL_FEEDER_BYTE_CNT_EN
  logic [15:0] tx_count;
`endif

  int passed = 0;
  int total  = 0;

  logic [7:0] ds_word = 8'h5A;
  logic [2:0] ds_idx  = 3'd0;

  serial_feeder #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inv_req    (inv_req),
    .ser_bit    (ser_bit),
    .functional (functional),
    .word_done  (word_done),
    .fifo_level (fifo_level)
`ifdef SERIAL_FEEDER_BYTE_CNT_EN
    ,
    .tx_count   (tx_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream register: shift into the indexed bit, or invert and realign.
  always @(posedge clock) begin
    if (functional) begin
      ds_word[ds_idx] <= ser_bit;
      ds_idx          <= ds_idx + 3'd1;
    end else begin
      ds_word <= ~ds_word;
      ds_idx  <= 3'd0;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [15:0] seq;
    logic [7:0]  c3;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    inv_req  = 1'b0;

    #8;
    checkOutput("rst_ser_bit", 16'(ser_bit), 16'd0);
    checkOutput("rst_functional", 16'(functional), 16'd0);
    checkOutput("rst_word_done", 16'(word_done), 16'd0);
    checkOutput("rst_in_ready", 16'(in_ready), 16'd0);
    checkOutput("rst_fifo_level", 16'(fifo_level), 16'd0);

    #4 reset_n = 1'b1;
    #1;
    checkOutput("sync_functional", 16'(functional), 16'd0);

    for (int k = 0; k < 8; k++) begin
      tick(1);
      checkOutput("init_functional", 16'(functional), 16'd1);
      checkOutput("init_ser_bit", 16'(ser_bit), 16'd0);
      checkOutput("init_word_done", 16'(word_done), (k == 7) ? 16'd1 : 16'd0);
    end
    tick(1);
    checkOutput("init_ds_word", 16'(ds_word), 16'h00);

    $display("[TB] push 0xA5, 0x3C");
    in_valid = 1'b1;
    in_data  = 8'hA5;
    checkOutput("ab_in_ready", 16'(in_ready), 16'd1);
    tick(1);
    in_data = 8'h3C;
    tick(1);
    in_valid = 1'b0;
    checkOutput("ab_level", 16'(fifo_level), 16'd2);
    tick(6);
    seq = 16'h3CA5;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) checkOutput("ab_ds_a5", 16'(ds_word), 16'hA5);
      checkOutput("ab_ser_bit", 16'(ser_bit), 16'(seq[k]));
      checkOutput("ab_word_done", 16'(word_done), ((k % 8) == 7) ? 16'd1 : 16'd0);
      tick(1);
    end
    checkOutput("ab_ds_3c", 16'(ds_word), 16'h3C);
    tick(8);
    checkOutput("ab_ds_hold", 16'(ds_word), 16'h3C);
    checkOutput("ab_level_empty", 16'(fifo_level), 16'd0);

    $display("[TB] invert request at bit 3");
    tick(3);
    inv_req = 1'b1;
    tick(1);
    inv_req = 1'b0;
    tick(3);
    checkOutput("inv_last_done", 16'(word_done), 16'd1);
    checkOutput("inv_last_func", 16'(functional), 16'd1);
    tick(1);
    checkOutput("inv_func", 16'(functional), 16'd0);
    checkOutput("inv_ser_bit", 16'(ser_bit), 16'd0);
    checkOutput("inv_word_done", 16'(word_done), 16'd0);
    tick(1);
    checkOutput("inv_ds_c3", 16'(ds_word), 16'hC3);
    checkOutput("inv_func_back", 16'(functional), 16'd1);
    c3 = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      checkOutput("inv_refill_bit", 16'(ser_bit), 16'(c3[k]));
      tick(1);
    end
    checkOutput("inv_ds_hold", 16'(ds_word), 16'hC3);

    $display("[TB] fill FIFO with 0x01..0x05");
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1);
      checkOutput("fill_ready", 16'(in_ready), 16'd1);
      tick(1);
    end
    checkOutput("full_level", 16'(fifo_level), 16'd4);
    checkOutput("full_ready", 16'(in_ready), 16'd0);
    in_data = 8'h05;
    tick(3);
    checkOutput("stall_ready", 16'(in_ready), 16'd0);
    checkOutput("stall_level", 16'(fifo_level), 16'd4);
    tick(1);
    checkOutput("pop_level", 16'(fifo_level), 16'd3);
    checkOutput("pop_ready", 16'(in_ready), 16'd1);
    tick(1);
    in_valid = 1'b0;
    checkOutput("refull_level", 16'(fifo_level), 16'd4);
    checkOutput("refull_ready", 16'(in_ready), 16'd0);
    tick(7);
    checkOutput("order_ds_01", 16'(ds_word), 16'h01);
    checkOutput("order_level", 16'(fifo_level), 16'd3);
    for (int b = 2; b <= 5; b++) begin
      tick(8);
      checkOutput("order_ds", 16'(ds_word), 16'(b));
    end

    $display("[TB] reset during 0x77");
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick(1);
    in_valid = 1'b0;
    tick(11);
    checkOutput("mid_ser_bit", 16'(ser_bit), 16'd1);
    checkOutput("mid_func", 16'(functional), 16'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mr_ser_bit", 16'(ser_bit), 16'd0);
    checkOutput("mr_functional", 16'(functional), 16'd0);
    checkOutput("mr_word_done", 16'(word_done), 16'd0);
    checkOutput("mr_in_ready", 16'(in_ready), 16'd0);
    checkOutput("mr_fifo_level", 16'(fifo_level), 16'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    #1;
    checkOutput("mr_sync_func", 16'(functional), 16'd0);
    in_valid = 1'b1;
    in_data  = 8'h81;
    tick(1);
    checkOutput("mr_ready", 16'(in_ready), 16'd1);
    checkOutput("mr_func_shift", 16'(functional), 16'd1);
    tick(1);
    in_valid = 1'b0;
    checkOutput("mr_level", 16'(fifo_level), 16'd1);
    tick(7);
    checkOutput("mr_ds_zero", 16'(ds_word), 16'h00);
    checkOutput("mr_bit0", 16'(ser_bit), 16'd1);
    checkOutput("mr_level_pop", 16'(fifo_level), 16'd0);
    tick(8);
    checkOutput("mr_ds_81", 16'(ds_word), 16'h81);
`ifdef SERIAL_FEEDER_BYTE_CNT_EN
    checkOutput("mr_tx_count", tx_count, 16'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_feeder.md
Name: serial_feeder

Overview:
- Upstream stage for the 8-bit serial-in shift register.
- Accepts parallel bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte LSB first, one bit per clock, onto the register's serial input.
- Drives the register's `functional` line:
  - held 1 while shifting;
  - pulsed to 0 for exactly one cycle to command a word inversion and realign the register's bit index to 0.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- WIDTH, 8, bits per word; fixed to match the downstream register, not to be overridden.

Ports:
- clock  in  1  single rising-edge clock, shared with the downstream register.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  byte to transmit.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO not full; transfer occurs when in_valid && in_ready on a rising edge.
- inv_req  in  1  single-cycle request to invert the downstream word.
- ser_bit  out  1  serial data; connects to the register's serial input.
- functional  out  1  1 = shift, 0 = invert and realign; connects to the register's functional input.
- word_done  out  1  one-cycle pulse in the cycle the last bit (index 7) of a word is presented.
- fifo_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- All outputs are registered.
- Reset values:
  - ser_bit = 0, functional = 0, word_done = 0, in_ready = 0, fifo_level = 0;
  - state = SYNC, bit_idx = 0, shadow = 0x00, inv_pend = 0.
- The downstream register has no reset, so alignment is re-established after every reset:
  - SYNC lasts one cycle after reset deasserts, with functional = 0. This clears the downstream bit index.
  - SYNC then moves to SHIFT with cur = shadow = 0x00.
  - Consequence: the downstream word is forced to 0x00 within 9 cycles of reset release.
- SHIFT:
  - functional = 1, ser_bit = cur[bit_idx]; bit_idx increments each clock and wraps 7→0.
  - When bit_idx = 7: word_done = 1 and shadow ← cur.
  - At the 7→0 wrap, the next word is chosen in priority order:
    1. inv_pend set: go to INVERT.
    2. FIFO non-empty: cur ← pop.
    3. FIFO empty: cur ← shadow. This refill re-sends the same bits, so the downstream word is unchanged.
  - functional is never deasserted mid-word.
- INVERT:
  - Lasts one cycle: functional = 0, ser_bit = 0.
  - shadow ← ~shadow, cur ← ~shadow, bit_idx = 0, inv_pend cleared.
  - Returns to SHIFT. The next word is chosen by the same rule (FIFO pop, otherwise cur = inverted shadow).
- inv_req handling:
  - Sets inv_pend on any cycle.
  - Multiple requests before service collapse into one inversion.
  - A request arriving in the same cycle as a pending service is absorbed by it.
- Latency:
  - With the FIFO empty and the engine at bit_idx 0, a byte accepted at edge t has its bit 0 presented at the next wrap, i.e. the edge ending the current 8-bit refill word.
  - Throughput is one byte per 8 cycles.
  - Each INVERT adds 1 cycle.
- FIFO:
  - in_ready = (fifo_level < DEPTH).
  - Simultaneous push and pop on a full FIFO is allowed: level unchanged, in_ready stays 0 for that cycle.
  - Pushes when in_ready = 0 are ignored.
- Reset mid-word:
  - Asynchronous return to reset values; the FIFO is flushed.
  - The partial word is lost; SYNC realigns the downstream register.

Optional Feature:
- Macro: SERIAL_FEEDER_BYTE_CNT_EN.
- With the macro defined:
  - adds output `tx_count` (16 bits), reset 0;
  - increments at each wrap where the word just completed came from a FIFO pop (refill and post-INVERT refill words are not counted);
  - wraps 0xFFFF→0.
- Without the macro: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package `serial_feeder_pkg`:
  - state enum {SYNC, SHIFT, INVERT};
  - WORD_W = 8;
  - BIT_IDX_W = 3.
- Sub-module `feeder_fifo`:
  - synchronous single-clock FIFO (DEPTH × WORD_W);
  - signals: push, pop, full, empty, level;
  - async active-low reset.
- The FSM, bit counter and shadow register stay in the top module.

Test Plan:
- Reset release, no input:
  - cycle 0 has functional = 0;
  - then 8 bits of 0 with functional = 1, word_done on the 8th bit;
  - the model of the downstream register reads 0x00 and stays 0x00 indefinitely.
- Push 0xA5 then 0x3C back-to-back:
  - ser_bit sequence 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0;
  - the downstream model shows 0xA5, then 0x3C, then holds 0x3C during refill.
- After 0x3C is loaded, pulse inv_req at bit_idx 3:
  - the current word completes;
  - one cycle with functional = 0 follows, and the downstream model reads 0xC3;
  - the refill then re-sends 0xC3 and the model holds 0xC3.
- Push 5 bytes 0x01..0x05 with DEPTH = 4 while the engine is busy:
  - in_ready drops to 0 at fifo_level = 4 and the 5th push stalls;
  - it is accepted on the cycle after the next pop;
  - all 5 bytes are delivered in order.
- Assert reset_n low at bit_idx 4 of 0x77, release it, push 0x81:
  - outputs return to reset values immediately;
  - SYNC occurs, then 0x00 refill, then 0x81 lands aligned in the downstream model;
  - with SERIAL_FEEDER_BYTE_CNT_EN, tx_count = 1.
